serial_sub4b: RTL
=================

# serial_sub4b

Bit-serial subtractor computing `a - b` one bit per clock, LSB first. It uses a single full-adder cell with two's-complement addition, `a + ~b + 1`. It is the inverse-direction companion to the team's combinational 4-bit adder and trades latency for area. A start/busy/done handshake lets a host or tile controller launch an operation and collect a held result.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; legal range 2–16.

Ports:
- `clk`  input  1: the single clock; all state changes on the rising edge.
- `rst`  input  1: reset; synchronous and active-high.
- `start`  input  1: request; sampled on a rising edge only while `busy`=0.
- `a`  input  WIDTH: minuend; captured on the accepting edge.
- `b`  input  WIDTH: subtrahend; captured on the accepting edge.
- `busy`  output  1: high while bits are being processed.
- `done`  output  1: one-cycle pulse when a new result is valid.
- `diff`  output  WIDTH: `(a - b) mod 2^WIDTH`; held until the next completion.
- `borrow`  output  1: 1 when a < b (unsigned), i.e. inverted final carry.
- `zero`  output  1: 1 when `diff` == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → capture `a` into shift register SA and `~b` into shift register SB.
  - carry flop ← 1; bit counter ← 0; go to RUN.
  - `start`=0 → stay in IDLE.
- RUN:
  - Each edge feeds the full adder with SA[0], SB[0] and the carry flop.
  - Sum bit shifts into the MSB of the result shift register; SA and SB shift right; carry flop ← cout; counter increments.
  - On the edge that processes bit WIDTH-1:
    - `diff` ← completed result register.
    - `borrow` ← ~cout.
    - `zero` ← (completed result == 0).
    - Go to DONE.
- DONE: lasts exactly one cycle, with `done`=1.
  - `start`=1 → accepted exactly as in IDLE; go to RUN (back-to-back operation).
  - Otherwise → go to IDLE.
- `start` in RUN is ignored and is not queued. Operand changes during RUN have no effect.
- `diff`, `borrow` and `zero` change only on a completing edge or on reset. They are never altered mid-operation.
- Arithmetic is unsigned modulo 2^WIDTH. `borrow` doubles as the unsigned a<b flag.
- For signed interpretation, overflow is out of scope; the host derives it.

## Timing
- Reset: `rst`=1 at an edge forces the following, regardless of state:
  - IDLE state.
  - `busy`=0, `done`=0, `diff`=0, `borrow`=0, `zero`=0.
  - Internal shift registers, counter and carry cleared.
- Reset mid-RUN abandons the operation; no `done` pulse is produced.
- `start` and `rst` at the same edge: reset wins.
- Accepting edge t (IDLE or DONE, `start`=1):
  - `busy`=1 from t to t+WIDTH.
  - Bit i is processed at edge t+1+i.
- Completing edge t+WIDTH:
  - `busy`→0, `done`→1.
  - `diff`, `borrow` and `zero` are updated at this same edge.
- `done` falls at edge t+WIDTH+1.
- Latency start→done is WIDTH edges. For WIDTH=4: `start` seen at edge 0, `done` high between edges 4 and 5.
- Throughput: one result per WIDTH+1 cycles with `start` held high continuously. The DONE cycle is the accepting cycle.
- `busy` and `done` are never high simultaneously.

## Test plan
- Reset then idle: assert `rst` 2 cycles, release, hold `start`=0 for 10 cycles → all outputs 0 throughout, no `done` pulse.
- Basic subtract: WIDTH=4, a=9, b=3, pulse `start` → `busy` high 4 cycles, then `done` pulse with `diff`=6, `borrow`=0, `zero`=0.
- Underflow and zero:
  - a=3, b=9 → `diff`=10 (0xA), `borrow`=1.
  - Then a=15, b=15 → `diff`=0, `borrow`=0, `zero`=1.
  - Outputs hold between operations.
- Start during busy: launch a=12, b=5. Pulse `start` with a=1, b=2 two cycles later → single `done` with `diff`=7, `borrow`=0; no second result.
- Back-to-back: hold `start`=1 with a=8, b=1, then a=0, b=1 presented in the DONE cycle:
  - `done` pulses 5 cycles apart.
  - Results are `diff`=7/`borrow`=0, then `diff`=15/`borrow`=1.
- Reset mid-operation:
  - Launch a=10, b=4, assert `rst` at the 2nd RUN edge → no `done`, outputs 0, `busy`=0.
  - A fresh a=10, b=4 then yields `diff`=6 after exactly 4 edges.

Source files
------------

// File: rtl/serial_sub4b.sv
// Bit-serial subtractor: a - b computed LSB first through one full-adder cell
// as a + ~b + 1, with a start/busy/done handshake and held results.
module serial_sub4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   sa_reg, sa_next;
  logic [WIDTH-1:0]   sb_reg, sb_next;
  logic [WIDTH-1:0]   res_reg, res_next;
  logic               carry_reg, carry_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   diff_reg, diff_next;
  logic               borrow_reg, borrow_next;
  logic               zero_reg, zero_next;

  logic               sum_bit;
  logic               cout_bit;
  logic               last_bit;
  logic [WIDTH-1:0]   res_shift;

  // The single full-adder cell shared by every bit position.
  assign sum_bit   = sa_reg[0] ^ sb_reg[0] ^ carry_reg;
  assign cout_bit  = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & carry_reg) |
                     (sb_reg[0] & carry_reg);
  assign res_shift = {sum_bit, res_reg[WIDTH-1:1]};
  assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next  = state_reg;
    sa_next     = sa_reg;
    sb_next     = sb_reg;
    res_next    = res_reg;
    carry_next  = carry_reg;
    cnt_next    = cnt_reg;
    diff_next   = diff_reg;
    borrow_next = borrow_reg;
    zero_next   = zero_reg;

    case (state_reg)
      IDLE, DONE: begin
        // DONE accepts a new request just like IDLE so back-to-back starts
        // lose no cycle.
        if (start) begin
          sa_next    = a;
          sb_next    = ~b;
          res_next   = '0;
          carry_next = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        sa_next    = sa_reg >> 1;
        sb_next    = sb_reg >> 1;
        res_next   = res_shift;
        carry_next = cout_bit;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (last_bit) begin
          diff_next   = res_shift;
          borrow_next = ~cout_bit;
          zero_next   = (res_shift == '0);
          state_next  = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      res_reg    <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      res_reg    <= res_next;
      carry_reg  <= carry_next;
      cnt_reg    <= cnt_next;
      diff_reg   <= diff_next;
      borrow_reg <= borrow_next;
      zero_reg   <= zero_next;
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign diff   = diff_reg;
  assign borrow = borrow_reg;
  assign zero   = zero_reg;

endmodule
